quad_encoder_counter: RTL

//  Input end of the rotary-encoder display path. Samples the raw rotary-encoder pins (A, B, push

---
 rtl/quad_encoder_counter_if.sv | 36 +++
 rtl/quad_encoder_counter.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/quad_encoder_counter_if.sv
// -----------------------------------------------------------------------------
// quad_encoder_counter_if
// Signal bundle between the raw rotary-encoder pins and the display path.
//   enc_a, enc_b  raw quadrature channels (asynchronous)
//   enc_btn       raw push button, active-high (asynchronous)
//   enc_swt       raw slide switch (asynchronous)
//   disp_val      current position count (5 bits)
//   swt           debounced switch level (display enable)
//   step_cw       one-cycle pulse per clockwise detent
//   step_ccw      one-cycle pulse per counter-clockwise detent
//   seq_err       one-cycle pulse on an illegal A/B transition
// Modports:
//   slave  - used by the counter (pins in, display signals out)
//   master - used by whatever drives the pins and consumes the display signals
// -----------------------------------------------------------------------------
interface quad_encoder_counter_if;
    logic       enc_a;
    logic       enc_b;
    logic       enc_btn;
    logic       enc_swt;
    logic [4:0] disp_val;
    logic       swt;
    logic       step_cw;
    logic       step_ccw;
    logic       seq_err;

    modport slave (
        input  enc_a, enc_b, enc_btn, enc_swt,
        output disp_val, swt, step_cw, step_ccw, seq_err
    );

    modport master (
        output enc_a, enc_b, enc_btn, enc_swt,
        input  disp_val, swt, step_cw, step_ccw, seq_err
    );
endinterface

// File: rtl/quad_encoder_counter.sv
// -----------------------------------------------------------------------------
// quad_encoder_counter
// Input end of the rotary-encoder display path. Synchronises and debounces the
// four raw encoder pins, decodes the quadrature into one step per detent and
// keeps a 0..MAX_VAL position count for the seven-segment driver.
//
// Ports:
//   clk    system clock, all logic on posedge
//   rst_n  asynchronous active-low reset
//   bus    quad_encoder_counter_if.slave
//            in : enc_a, enc_b, enc_btn, enc_swt (raw, asynchronous)
//            out: disp_val, swt, step_cw, step_ccw, seq_err
//
// Parameters:
//   DEBOUNCE_CYCLES  stable synced cycles before a filtered input follows it
//   MAX_VAL          highest count value, must be < 32
//
// Build option:
//   ENC_SATURATE_EN  when defined, the count holds at MAX_VAL (CW) and at 0
//                    (CCW) instead of wrapping; step pulses are unaffected.
// -----------------------------------------------------------------------------
module quad_encoder_counter #(
    parameter int DEBOUNCE_CYCLES = 5000,
    parameter int MAX_VAL         = 19
) (
    input logic                  clk,
    input logic                  rst_n,
    quad_encoder_counter_if.slave bus
);

    localparam int             CNT_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [4:0]     MAX_V    = 5'(MAX_VAL);

    // Channel order: 0=A, 1=B, 2=button, 3=switch. Filtered A/B come out of
    // reset at the detent rest level so the FSM starts consistent with IDLE.
    localparam logic [3:0] FILT_RST = 4'b0011;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_CW1  = 3'd1;
    localparam logic [2:0] S_CW2  = 3'd2;
    localparam logic [2:0] S_CW3  = 3'd3;
    localparam logic [2:0] S_CCW1 = 3'd4;
    localparam logic [2:0] S_CCW2 = 3'd5;
    localparam logic [2:0] S_CCW3 = 3'd6;
    localparam logic [2:0] S_WAIT = 3'd7;

    logic [3:0] raw;
    logic [3:0] sync_p0;
    logic [3:0] sync_p1;
    logic [3:0] filt;

    assign raw = {bus.enc_swt, bus.enc_btn, bus.enc_b, bus.enc_a};

    // ---- stage p0/p1: two-flop synchroniser on every raw pin
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_p0 <= '0;
            sync_p1 <= '0;
        end else begin
            sync_p0 <= raw;
            sync_p1 <= sync_p0;
        end
    end

    // ---- debounce: filtered value follows the synced value only after it has
    // differed for DEBOUNCE_CYCLES consecutive cycles
    for (genvar i = 0; i < 4; i++) begin : g_db
        logic [CNT_W-1:0] cnt_q;
        logic             filt_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt_q  <= '0;
                filt_q <= FILT_RST[i];
            end else if (sync_p1[i] == filt_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CNT_LAST) begin
                cnt_q  <= '0;
                filt_q <= sync_p1[i];
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end

        assign filt[i] = filt_q;
    end

    function automatic logic [4:0] cw_next(input logic [4:0] v);
`ifdef ENC_SATURATE_EN
        return (v == MAX_V) ? MAX_V : v + 5'd1;
`else
        return (v == MAX_V) ? 5'd0 : v + 5'd1;
`endif
    endfunction

    function automatic logic [4:0] ccw_next(input logic [4:0] v);
`ifdef ENC_SATURATE_EN
        return (v == 5'd0) ? 5'd0 : v - 5'd1;
`else
        return (v == 5'd0) ? MAX_V : v - 5'd1;
`endif
    endfunction

    logic [1:0] ab;
    logic [2:0] state_q;
    logic [2:0] state_d;
    logic       do_cw;
    logic       do_ccw;
    logic       do_err;

    assign ab = {filt[0], filt[1]};

    // ---- quadrature decode; a level equal to the state's own level holds it
    always_comb begin
        state_d = state_q;
        do_cw   = 1'b0;
        do_ccw  = 1'b0;
        do_err  = 1'b0;
        case (state_q)
            S_IDLE: case (ab)
                2'b01:   state_d = S_CW1;
                2'b10:   state_d = S_CCW1;
                2'b00:   begin state_d = S_WAIT; do_err = 1'b1; end
                default: ;
            endcase
            S_CW1: case (ab)
                2'b00:   state_d = S_CW2;
                2'b11:   state_d = S_IDLE;
                2'b10:   begin state_d = S_WAIT; do_err = 1'b1; end
                default: ;
            endcase
            S_CW2: case (ab)
                2'b10:   state_d = S_CW3;
                2'b01:   state_d = S_CW1;
                2'b11:   begin state_d = S_WAIT; do_err = 1'b1; end
                default: ;
            endcase
            S_CW3: case (ab)
                2'b11:   begin state_d = S_IDLE; do_cw = 1'b1; end
                2'b00:   state_d = S_CW2;
                2'b01:   begin state_d = S_WAIT; do_err = 1'b1; end
                default: ;
            endcase
            S_CCW1: case (ab)
                2'b00:   state_d = S_CCW2;
                2'b11:   state_d = S_IDLE;
                2'b01:   begin state_d = S_WAIT; do_err = 1'b1; end
                default: ;
            endcase
            S_CCW2: case (ab)
                2'b01:   state_d = S_CCW3;
                2'b10:   state_d = S_CCW1;
                2'b11:   begin state_d = S_WAIT; do_err = 1'b1; end
                default: ;
            endcase
            S_CCW3: case (ab)
                2'b11:   begin state_d = S_IDLE; do_ccw = 1'b1; end
                2'b00:   state_d = S_CCW2;
                2'b10:   begin state_d = S_WAIT; do_err = 1'b1; end
                default: ;
            endcase
            default: if (ab == 2'b11) state_d = S_IDLE;
        endcase
    end

    logic       btn_prev;
    logic       btn_rise;
    logic [4:0] val_q;
    logic       step_cw_q;
    logic       step_ccw_q;
    logic       seq_err_q;

    assign btn_rise = filt[2] & ~btn_prev;

    // ---- registered FSM state, count and pulses; a button edge clears the
    // count even when a detent completes on the same edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            btn_prev   <= 1'b0;
            val_q      <= 5'd0;
            step_cw_q  <= 1'b0;
            step_ccw_q <= 1'b0;
            seq_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            btn_prev   <= filt[2];
            step_cw_q  <= do_cw;
            step_ccw_q <= do_ccw;
            seq_err_q  <= do_err;
            if (btn_rise)
                val_q <= 5'd0;
            else if (do_cw)
                val_q <= cw_next(val_q);
            else if (do_ccw)
                val_q <= ccw_next(val_q);
        end
    end

    assign bus.disp_val = val_q;
    assign bus.swt      = filt[3];
    assign bus.step_cw  = step_cw_q;
    assign bus.step_ccw = step_ccw_q;
    assign bus.seq_err  = seq_err_q;

endmodule
